// File: rtl/array_playback_reader.sv
// Circular sample-array reader: a DEPTH x DATA_W array with an always-open write port.
// Streams a burst of entries from start_addr over valid/ready, wrapping modulo DEPTH.
module array_playback_reader #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   length,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              busy,
  output logic              done,
  output logic [7:0]        beat_count
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t              state;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]   rd_ptr;
  logic [ADDR_W:0]     remaining;

  logic [ADDR_W-1:0]   nxt_ptr;
  logic [ADDR_W-1:0]   load_addr;
  logic [DATA_W-1:0]   load_val;
  logic [ADDR_W:0]     len_clamped;
  logic                accept;

  // Array has no reset: contents survive rst and writes are taken every cycle.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign nxt_ptr     = rd_ptr + 1'b1;
  assign load_addr   = (state == IDLE) ? start_addr : nxt_ptr;
  // A write landing on the entry being loaded this edge wins over the stale array word.
  assign load_val    = (wr_en && (wr_addr == load_addr)) ? wr_data : mem[load_addr];
  assign len_clamped = (length > DEPTH_L) ? DEPTH_L : length;
  assign accept      = data_valid && data_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rd_ptr     <= '0;
      remaining  <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      beat_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && (length != '0)) begin
            state      <= STREAM;
            rd_ptr     <= start_addr;
            remaining  <= len_clamped;
            data_out   <= load_val;
            data_valid <= 1'b1;
            busy       <= 1'b1;
          end
        end
        STREAM: begin
          if (accept) begin
            beat_count <= beat_count + 8'd1;
            remaining  <= remaining - 1'b1;
            if (remaining == (ADDR_W+1)'(1)) begin
              // Last beat: data_out keeps the final word for observers.
              state      <= IDLE;
              data_valid <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
            end else begin
              rd_ptr   <= nxt_ptr;
              data_out <= load_val;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
